// File: rtl/dmem_port_arbiter.sv
// Shares the data-memory SRAM port between the CPU MEM stage and an external requester.
// Optional starvation guard is built when DMEM_ARB_STARVE_GUARD_EN is defined.
module dmem_port_arbiter #(
   parameter int ADDR_W   = 64,
   parameter int DATA_W   = 64,
   parameter int MAX_WAIT = 8
) (
   input  logic              clk,
   input  logic              srst,
   input  logic              enable,
   input  logic              cpu_req,
   input  logic              cpu_wen,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_stall,
   output logic              cpu_rvalid,
   output logic [DATA_W-1:0] cpu_rdata,
   input  logic              ext_valid,
   output logic              ext_ready,
   input  logic              ext_wen,
   input  logic [ADDR_W-1:0] ext_addr,
   input  logic [DATA_W-1:0] ext_wdata,
   output logic              ext_rvalid,
   output logic [DATA_W-1:0] ext_rdata,
   output logic              mem_ren,
   output logic              mem_wen,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [1:0]        dbg_owner,
   output logic [7:0]        dbg_wait
);

   // Handshake: the external request transfers in a cycle where ext_valid & ext_ready;
   // ext_valid and its fields are held stable by the requester until then.
   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_CPU  = 2'd1,
      OWN_EXT  = 2'd2
   } owner_t;

   if (MAX_WAIT < 1 || MAX_WAIT > 255) begin : g_bad_max_wait
      $error("dmem_port_arbiter: MAX_WAIT must be in 1..255");
   end

   logic   c_req;
   logic   e_req;
   logic   force_ext;
   owner_t grant;
   owner_t owner_q;
   logic [7:0] wait_q;

   assign c_req = cpu_req & enable;
   assign e_req = ext_valid;

`ifdef DMEM_ARB_STARVE_GUARD_EN
   localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT);

   // Counts cycles the external request sat unserved; saturates so force stays asserted.
   always_ff @(posedge clk) begin
      if (srst) begin
         wait_q <= 8'd0;
      end else if (!ext_valid || ext_ready) begin
         wait_q <= 8'd0;
      end else if (wait_q != WAIT_LIMIT) begin
         wait_q <= wait_q + 8'd1;
      end
   end

   assign force_ext = (wait_q == WAIT_LIMIT);
`else
   assign wait_q    = 8'd0;
   assign force_ext = 1'b0;
`endif

   always_comb begin
      grant = OWN_NONE;
      if (force_ext) begin
         if (e_req) begin
            grant = OWN_EXT;
         end else if (c_req) begin
            grant = OWN_CPU;
         end
      end else begin
         if (c_req) begin
            grant = OWN_CPU;
         end else if (e_req) begin
            grant = OWN_EXT;
         end
      end
   end

   always_comb begin
      mem_ren   = 1'b0;
      mem_wen   = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      case (grant)
         OWN_CPU: begin
            mem_ren   = ~cpu_wen;
            mem_wen   = cpu_wen;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
         end
         OWN_EXT: begin
            mem_ren   = ~ext_wen;
            mem_wen   = ext_wen;
            mem_addr  = ext_addr;
            mem_wdata = ext_wdata;
         end
         default: begin
            mem_ren   = 1'b0;
            mem_wen   = 1'b0;
            mem_addr  = '0;
            mem_wdata = '0;
         end
      endcase
   end

   assign ext_ready = (grant == OWN_EXT);
   assign cpu_stall = c_req & (grant == OWN_EXT);

   // Remembers who issued last cycle's read so the 1-cycle SRAM return is steered correctly.
   always_ff @(posedge clk) begin
      if (srst) begin
         owner_q <= OWN_NONE;
      end else if (grant == OWN_CPU && !cpu_wen) begin
         owner_q <= OWN_CPU;
      end else if (grant == OWN_EXT && !ext_wen) begin
         owner_q <= OWN_EXT;
      end else begin
         owner_q <= OWN_NONE;
      end
   end

   assign cpu_rvalid = (owner_q == OWN_CPU);
   assign ext_rvalid = (owner_q == OWN_EXT);
   assign cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
   assign ext_rdata  = ext_rvalid ? mem_rdata : '0;

   assign dbg_owner = owner_q;
   assign dbg_wait  = wait_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter: vector table plus hand-written multi-cycle sequences.
module tb_dmem_port_arbiter;

`ifdef DMEM_ARB_STARVE_GUARD_EN
   localparam bit GUARD = 1'b1;
`else
   localparam bit GUARD = 1'b0;
`endif

   logic        clk;
   logic        srst;
   logic        enable;
   logic        cpu_req;
   logic        cpu_wen;
   logic [63:0] cpu_addr;
   logic [63:0] cpu_wdata;
   logic        cpu_stall;
   logic        cpu_rvalid;
   logic [63:0] cpu_rdata;
   logic        ext_valid;
   logic        ext_ready;
   logic        ext_wen;
   logic [63:0] ext_addr;
   logic [63:0] ext_wdata;
   logic        ext_rvalid;
   logic [63:0] ext_rdata;
   logic        mem_ren;
   logic        mem_wen;
   logic [63:0] mem_addr;
   logic [63:0] mem_wdata;
   logic [63:0] mem_rdata;
   logic [1:0]  dbg_owner;
   logic [7:0]  dbg_wait;

   int total = 0;
   int bad   = 0;
   logic [63:0] exp_q[$];
   logic [63:0] sram [0:255];

   dmem_port_arbiter #(.ADDR_W(64), .DATA_W(64), .MAX_WAIT(3)) dut (
      .clk(clk), .srst(srst), .enable(enable),
      .cpu_req(cpu_req), .cpu_wen(cpu_wen), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
      .ext_valid(ext_valid), .ext_ready(ext_ready), .ext_wen(ext_wen),
      .ext_addr(ext_addr), .ext_wdata(ext_wdata),
      .ext_rvalid(ext_rvalid), .ext_rdata(ext_rdata),
      .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .dbg_owner(dbg_owner), .dbg_wait(dbg_wait)
   );

   // clock / SRAM model with 1-cycle read latency, word index = addr[10:3]
   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_wen) sram[mem_addr[10:3]] <= mem_wdata;
      if (mem_ren) mem_rdata <= sram[mem_addr[10:3]];
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic drive_cpu(input logic en, input logic req, input logic wen,
                            input logic [63:0] addr, input logic [63:0] wdata);
      enable    = en;
      cpu_req   = req;
      cpu_wen   = wen;
      cpu_addr  = addr;
      cpu_wdata = wdata;
   endtask

   task automatic drive_ext(input logic v, input logic wen,
                            input logic [63:0] addr, input logic [63:0] wdata);
      ext_valid = v;
      ext_wen   = wen;
      ext_addr  = addr;
      ext_wdata = wdata;
   endtask

   task automatic drive_idle();
      drive_cpu(1'b1, 1'b0, 1'b0, 64'h0, 64'h0);
      drive_ext(1'b0, 1'b0, 64'h0, 64'h0);
   endtask

   typedef struct {
      logic        en, creq, cwen;
      logic [63:0] caddr, cwdata;
      logic        ev, ewen;
      logic [63:0] eaddr, ewdata;
      logic        x_ren, x_wen;
      logic [63:0] x_addr, x_wdata;
      logic        x_ready, x_stall;
      logic        x_crv, x_erv;
      logic [63:0] x_rdata;
      logic [7:0]  x_wait;
   } vec_t;

   vec_t vecs[7];

   initial begin
      for (int i = 0; i < 256; i++) sram[i] = 64'h0;
      sram[8] = 64'hDEAD_BEEF;   // 0x40
      sram[2] = 64'h1111;        // 0x10
      sram[3] = 64'h2222;        // 0x18
      mem_rdata = 64'h0;

      //          en creq cwen caddr    cwdata  ev ewen eaddr    ewdata   ren wen addr     wdata    rdy stl crv erv rdata           wait
      vecs[0] = '{1, 0, 0, 64'h00, 64'h00, 0, 0, 64'h00, 64'h00, 0, 0, 64'h00, 64'h00, 0, 0, 0, 0, 64'h0,          8'd0};
      vecs[1] = '{1, 1, 0, 64'h40, 64'h00, 0, 0, 64'h00, 64'h00, 1, 0, 64'h40, 64'h00, 0, 0, 1, 0, 64'hDEAD_BEEF, 8'd0};
      vecs[2] = '{1, 1, 1, 64'h48, 64'h55, 0, 0, 64'h00, 64'h00, 0, 1, 64'h48, 64'h55, 0, 0, 0, 0, 64'h0,          8'd0};
      vecs[3] = '{1, 0, 0, 64'h00, 64'h00, 1, 0, 64'h10, 64'h00, 1, 0, 64'h10, 64'h00, 1, 0, 0, 1, 64'h1111,       8'd0};
      vecs[4] = '{1, 1, 0, 64'h18, 64'h00, 1, 1, 64'h80, 64'h99, 1, 0, 64'h18, 64'h00, 0, 0, 1, 0, 64'h2222,       GUARD ? 8'd1 : 8'd0};
      vecs[5] = '{0, 1, 0, 64'h40, 64'h00, 0, 0, 64'h00, 64'h00, 0, 0, 64'h00, 64'h00, 0, 0, 0, 0, 64'h0,          8'd0};
      vecs[6] = '{0, 1, 0, 64'h40, 64'h00, 1, 1, 64'h20, 64'h77, 0, 1, 64'h20, 64'h77, 1, 0, 0, 0, 64'h0,          8'd0};

      // reset then idle
      drive_idle();
      srst = 1'b1;
      repeat (2) @(negedge clk);
      srst = 1'b0;
      @(negedge clk);
      #1;
      chk("rst_mem_ren", mem_ren, 0);
      chk("rst_mem_wen", mem_wen, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      chk("rst_cpu_rvalid", cpu_rvalid, 0);
      chk("rst_ext_rvalid", ext_rvalid, 0);
      chk("rst_cpu_rdata", cpu_rdata, 0);
      chk("rst_ext_rdata", ext_rdata, 0);
      chk("rst_ext_ready", ext_ready, 0);
      chk("rst_cpu_stall", cpu_stall, 0);
      chk("rst_owner", dbg_owner, 0);
      chk("rst_wait", dbg_wait, 0);

      // table vectors: one active cycle, then an idle cycle to settle
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         drive_cpu(vecs[i].en, vecs[i].creq, vecs[i].cwen, vecs[i].caddr, vecs[i].cwdata);
         drive_ext(vecs[i].ev, vecs[i].ewen, vecs[i].eaddr, vecs[i].ewdata);
         #1;
         chk($sformatf("v%0d_mem_ren", i), mem_ren, vecs[i].x_ren);
         chk($sformatf("v%0d_mem_wen", i), mem_wen, vecs[i].x_wen);
         chk($sformatf("v%0d_mem_addr", i), mem_addr, vecs[i].x_addr);
         chk($sformatf("v%0d_mem_wdata", i), mem_wdata, vecs[i].x_wdata);
         chk($sformatf("v%0d_ext_ready", i), ext_ready, vecs[i].x_ready);
         chk($sformatf("v%0d_cpu_stall", i), cpu_stall, vecs[i].x_stall);
         @(negedge clk);
         chk($sformatf("v%0d_cpu_rvalid", i), cpu_rvalid, vecs[i].x_crv);
         chk($sformatf("v%0d_ext_rvalid", i), ext_rvalid, vecs[i].x_erv);
         chk($sformatf("v%0d_cpu_rdata", i), cpu_rdata, vecs[i].x_crv ? vecs[i].x_rdata : 64'h0);
         chk($sformatf("v%0d_ext_rdata", i), ext_rdata, vecs[i].x_erv ? vecs[i].x_rdata : 64'h0);
         chk($sformatf("v%0d_wait", i), dbg_wait, vecs[i].x_wait);
         drive_idle();
      end

      // starvation: constant CPU reads, external write of 0x1234 to 0x80
      @(negedge clk);
      drive_cpu(1'b1, 1'b1, 1'b0, 64'h18, 64'h0);
      drive_ext(1'b1, 1'b1, 64'h80, 64'h1234);
      for (int cyc = 0; cyc < 5; cyc++) begin
         logic exp_ext;
         if (cyc > 0) @(negedge clk);
         if (cyc == 4 && GUARD) ext_valid = 1'b0;
         exp_ext = GUARD && (cyc == 3);
         #1;
         chk($sformatf("starve%0d_ext_ready", cyc), ext_ready, exp_ext);
         chk($sformatf("starve%0d_cpu_stall", cyc), cpu_stall, exp_ext);
         chk($sformatf("starve%0d_mem_wen", cyc), mem_wen, exp_ext);
         chk($sformatf("starve%0d_mem_ren", cyc), mem_ren, !exp_ext);
         chk($sformatf("starve%0d_mem_addr", cyc), mem_addr, exp_ext ? 64'h80 : 64'h18);
         chk($sformatf("starve%0d_wait", cyc), dbg_wait,
             GUARD ? ((cyc == 4) ? 8'd0 : 8'(cyc)) : 8'd0);
      end
      @(negedge clk);
      drive_idle();
      @(negedge clk);
      drive_cpu(1'b0, 1'b0, 1'b0, 64'h0, 64'h0);
      drive_ext(1'b1, 1'b0, 64'h80, 64'h0);
      @(negedge clk);
      drive_idle();
      chk("starve_readback", ext_rdata, GUARD ? 64'h1234 : 64'h0);

      // alternating owners: EXT read 0x10 then CPU read 0x18
      @(negedge clk);
      drive_cpu(1'b0, 1'b0, 1'b0, 64'h0, 64'h0);
      drive_ext(1'b1, 1'b0, 64'h10, 64'h0);
      exp_q.push_back(64'h1111);
      @(negedge clk);
      drive_cpu(1'b1, 1'b1, 1'b0, 64'h18, 64'h0);
      drive_ext(1'b0, 1'b0, 64'h0, 64'h0);
      exp_q.push_back(64'h2222);
      chk("alt_ext_rvalid", ext_rvalid, 1);
      chk("alt_cpu_rvalid_n1", cpu_rvalid, 0);
      chk("alt_ext_rdata", ext_rdata, exp_q.pop_front());
      @(negedge clk);
      drive_idle();
      chk("alt_cpu_rvalid", cpu_rvalid, 1);
      chk("alt_ext_rvalid_n2", ext_rvalid, 0);
      chk("alt_cpu_rdata", cpu_rdata, exp_q.pop_front());

      // reset mid-read, with a pending external request having raised wait_q
      @(negedge clk);
      drive_cpu(1'b1, 1'b1, 1'b0, 64'h40, 64'h0);
      drive_ext(1'b1, 1'b0, 64'h10, 64'h0);
      @(negedge clk);
      srst = 1'b1;
      #1;
      chk("rstmid_mem_ren", mem_ren, 1);
      chk("rstmid_mem_addr", mem_addr, 64'h40);
      @(negedge clk);
      srst = 1'b0;
      drive_idle();
      chk("rstmid_cpu_rvalid", cpu_rvalid, 0);
      chk("rstmid_cpu_rdata", cpu_rdata, 0);
      chk("rstmid_wait", dbg_wait, 0);
      chk("rstmid_owner", dbg_owner, 0);

      repeat (2) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
